// File: rtl/urv_dm_sequencer.sv
// Data-memory access sequencer for load/store instructions at the execute/writeback boundary.
// Optional bus timeout abort enabled with `define URV_DM_TIMEOUT_EN.
module urv_dm_sequencer #(
  parameter int unsigned g_timeout_cycles = 255
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        x_valid_i,
  input  logic        x_load_i,
  input  logic        x_store_i,
  input  logic [2:0]  x_fun_i,
  input  logic [31:0] x_dm_addr_i,
  input  logic [31:0] x_dm_data_s_i,
  output logic [31:0] dm_addr_o,
  output logic [31:0] dm_data_s_o,
  output logic [3:0]  dm_data_select_o,
  output logic        dm_load_o,
  output logic        dm_store_o,
  input  logic        dm_ready_i,
  input  logic [31:0] dm_data_l_i,
  output logic [31:0] dm_data_l_o,
  output logic        dm_load_done_o,
  output logic        dm_store_done_o,
  output logic        dm_misaligned_o,
  output logic        dm_error_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [3:0]  sel_q, sel_d;
  logic        load_q, load_d;
  logic        store_q, store_d;
  logic        ldone_q, ldone_d;
  logic        sdone_q, sdone_d;
  logic        mis_q, mis_d;
  logic        err_q, err_d;

  logic        req_c;
  logic        misaligned_c;
  logic [3:0]  sel_c;
  logic [31:0] wdata_c;
  logic        unused_c;

  // Size decode uses fun[1:0] only; signedness is resolved downstream.
  assign unused_c = x_fun_i[2] ^ (g_timeout_cycles != 0);
  assign req_c    = x_valid_i & (x_load_i | x_store_i);

  always_comb begin
    misaligned_c = 1'b0;
    sel_c        = 4'b1111;
    wdata_c      = x_dm_data_s_i;
    case (x_fun_i[1:0])
      2'b00: begin
        sel_c   = 4'b0001 << x_dm_addr_i[1:0];
        wdata_c = {4{x_dm_data_s_i[7:0]}};
      end
      2'b01: begin
        misaligned_c = x_dm_addr_i[0];
        sel_c        = x_dm_addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_c      = {2{x_dm_data_s_i[15:0]}};
      end
      default: misaligned_c = (x_dm_addr_i[1:0] != 2'b00);
    endcase
  end

`ifdef URV_DM_TIMEOUT_EN
  localparam int unsigned CntW =
    ($clog2(g_timeout_cycles + 1) > 8) ? $clog2(g_timeout_cycles + 1) : 8;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            expire_c;
  assign expire_c = (cnt_q == CntW'(g_timeout_cycles - 1));
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    sel_d   = sel_q;
    load_d  = load_q;
    store_d = store_q;
    ldone_d = 1'b0;
    sdone_d = 1'b0;
    mis_d   = 1'b0;
    err_d   = 1'b0;
`ifdef URV_DM_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req_c) begin
          if (misaligned_c) begin
            state_d = ST_DONE;
            ldone_d = x_load_i;
            sdone_d = ~x_load_i;
            mis_d   = 1'b1;
          end else begin
            state_d = ST_WAIT;
            addr_d  = {x_dm_addr_i[31:2], 2'b00};
            wdata_d = wdata_c;
            sel_d   = sel_c;
            load_d  = x_load_i;
            store_d = ~x_load_i;
`ifdef URV_DM_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end
        end
      end
      ST_WAIT: begin
        if (dm_ready_i) begin
          state_d = ST_DONE;
          load_d  = 1'b0;
          store_d = 1'b0;
          ldone_d = load_q;
          sdone_d = store_q;
          if (load_q) rdata_d = dm_data_l_i;
        end
`ifdef URV_DM_TIMEOUT_EN
        else if (expire_c) begin
          state_d = ST_DONE;
          load_d  = 1'b0;
          store_d = 1'b0;
          ldone_d = load_q;
          sdone_d = store_q;
          err_d   = 1'b1;
          if (load_q) rdata_d = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
`endif
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      sel_q   <= '0;
      load_q  <= 1'b0;
      store_q <= 1'b0;
      ldone_q <= 1'b0;
      sdone_q <= 1'b0;
      mis_q   <= 1'b0;
      err_q   <= 1'b0;
`ifdef URV_DM_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      sel_q   <= sel_d;
      load_q  <= load_d;
      store_q <= store_d;
      ldone_q <= ldone_d;
      sdone_q <= sdone_d;
      mis_q   <= mis_d;
      err_q   <= err_d;
`ifdef URV_DM_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign dm_addr_o        = addr_q;
  assign dm_data_s_o      = wdata_q;
  assign dm_data_select_o = sel_q;
  assign dm_load_o        = load_q;
  assign dm_store_o       = store_q;
  assign dm_data_l_o      = rdata_q;
  assign dm_load_done_o   = ldone_q;
  assign dm_store_done_o  = sdone_q;
  assign dm_misaligned_o  = mis_q;
  assign dm_error_o       = err_q;

endmodule

// File: tb/tb_urv_dm_sequencer.sv
// Directed bench for urv_dm_sequencer; covers the timeout path when URV_DM_TIMEOUT_EN is defined.
module tb_urv_dm_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        x_valid_i, x_load_i, x_store_i;
  logic [2:0]  x_fun_i;
  logic [31:0] x_dm_addr_i, x_dm_data_s_i;
  logic [31:0] dm_addr_o, dm_data_s_o, dm_data_l_o;
  logic [3:0]  dm_data_select_o;
  logic        dm_load_o, dm_store_o, dm_ready_i;
  logic [31:0] dm_data_l_i;
  logic        dm_load_done_o, dm_store_done_o, dm_misaligned_o, dm_error_o;

  int tests = 0;
  int fails = 0;

  urv_dm_sequencer #(.g_timeout_cycles(4)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .x_valid_i(x_valid_i), .x_load_i(x_load_i), .x_store_i(x_store_i),
    .x_fun_i(x_fun_i), .x_dm_addr_i(x_dm_addr_i), .x_dm_data_s_i(x_dm_data_s_i),
    .dm_addr_o(dm_addr_o), .dm_data_s_o(dm_data_s_o), .dm_data_select_o(dm_data_select_o),
    .dm_load_o(dm_load_o), .dm_store_o(dm_store_o), .dm_ready_i(dm_ready_i),
    .dm_data_l_i(dm_data_l_i), .dm_data_l_o(dm_data_l_o),
    .dm_load_done_o(dm_load_done_o), .dm_store_done_o(dm_store_done_o),
    .dm_misaligned_o(dm_misaligned_o), .dm_error_o(dm_error_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic ld, input logic st, input logic [2:0] fun,
                     input logic [31:0] addr, input logic [31:0] data);
    x_valid_i = 1'b1; x_load_i = ld; x_store_i = st;
    x_fun_i = fun; x_dm_addr_i = addr; x_dm_data_s_i = data;
  endtask

  task automatic idle_in();
    x_valid_i = 1'b0; x_load_i = 1'b0; x_store_i = 1'b0;
  endtask

  initial begin
    rst_n_i = 1'b0; dm_ready_i = 1'b0; dm_data_l_i = '0;
    x_fun_i = '0; x_dm_addr_i = '0; x_dm_data_s_i = '0;
    idle_in();
    step(); step();
    chk("rst_load", 32'(dm_load_o), 32'd0);
    chk("rst_store", 32'(dm_store_o), 32'd0);
    chk("rst_addr", dm_addr_o, 32'h0);
    chk("rst_sel", 32'(dm_data_select_o), 32'h0);
    chk("rst_datal", dm_data_l_o, 32'h0);
    chk("rst_done", 32'({dm_load_done_o, dm_store_done_o, dm_misaligned_o, dm_error_o}), 32'h0);
    rst_n_i = 1'b1;
    step();

    // LB 0x103, ready on first strobe cycle
    req(1'b1, 1'b0, 3'b000, 32'h103, 32'h0);
    step();
    chk("lb_strobe", 32'(dm_load_o), 32'd1);
    chk("lb_addr", dm_addr_o, 32'h100);
    chk("lb_sel", 32'(dm_data_select_o), 32'b1000);
    chk("lb_nostore", 32'(dm_store_o), 32'd0);
    chk("lb_nodone_n1", 32'(dm_load_done_o), 32'd0);
    dm_ready_i = 1'b1; dm_data_l_i = 32'hAABBCCDD;
    step();
    chk("lb_done", 32'(dm_load_done_o), 32'd1);
    chk("lb_strobe_drop", 32'(dm_load_o), 32'd0);
    chk("lb_data", dm_data_l_o, 32'hAABBCCDD);
    chk("lb_nomis", 32'(dm_misaligned_o), 32'd0);
    dm_ready_i = 1'b0; dm_data_l_i = 32'h0;
    step();
    chk("lb_done_pulse", 32'(dm_load_done_o), 32'd0);
    chk("lb_no_reissue", 32'(dm_load_o), 32'd0);
    idle_in();
    step();

    // SH 0x202 with three wait cycles
    req(1'b0, 1'b1, 3'b001, 32'h202, 32'h0000BEEF);
    step();
    chk("sh_strobe", 32'(dm_store_o), 32'd1);
    chk("sh_sel", 32'(dm_data_select_o), 32'b1100);
    chk("sh_data", dm_data_s_o, 32'hBEEFBEEF);
    chk("sh_addr", dm_addr_o, 32'h200);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("sh_hold_strobe", 32'(dm_store_o), 32'd1);
      chk("sh_hold_data", dm_data_s_o, 32'hBEEFBEEF);
      chk("sh_hold_nodone", 32'(dm_store_done_o), 32'd0);
    end
    dm_ready_i = 1'b1;
    step();
    chk("sh_done", 32'(dm_store_done_o), 32'd1);
    chk("sh_strobe_drop", 32'(dm_store_o), 32'd0);
    chk("sh_datal_held", dm_data_l_o, 32'hAABBCCDD);
    dm_ready_i = 1'b0; idle_in();
    step();
    chk("sh_done_pulse", 32'(dm_store_done_o), 32'd0);

    // LW 0x301 misaligned
    req(1'b1, 1'b0, 3'b010, 32'h301, 32'h0);
    step();
    chk("lwmis_done", 32'(dm_load_done_o), 32'd1);
    chk("lwmis_flag", 32'(dm_misaligned_o), 32'd1);
    chk("lwmis_nostrobe", 32'({dm_load_o, dm_store_o}), 32'd0);
    idle_in();
    step();
    chk("lwmis_pulse", 32'({dm_load_done_o, dm_misaligned_o}), 32'd0);
    chk("lwmis_nostrobe2", 32'({dm_load_o, dm_store_o}), 32'd0);

    // HU store to odd address: misaligned store
    req(1'b0, 1'b1, 3'b101, 32'h11, 32'h1234);
    step();
    chk("shmis_done", 32'({dm_store_done_o, dm_load_done_o, dm_misaligned_o}), 32'b101);
    chk("shmis_nostrobe", 32'(dm_store_o), 32'd0);
    idle_in();
    step();

    // Back-to-back SB 0x0 then LW 0x4, zero-wait bus
    dm_ready_i = 1'b1; dm_data_l_i = 32'h12345678;
    req(1'b0, 1'b1, 3'b000, 32'h0, 32'h11);
    step();
    chk("sb_strobe", 32'(dm_store_o), 32'd1);
    chk("sb_sel", 32'(dm_data_select_o), 32'b0001);
    chk("sb_data", dm_data_s_o, 32'h11111111);
    step();
    chk("sb_done", 32'(dm_store_done_o), 32'd1);
    chk("sb_in_done_nostrobe", 32'(dm_store_o), 32'd0);
    step();
    chk("sb_not_reissued", 32'(dm_store_o), 32'd0);
    chk("sb_done_pulse", 32'(dm_store_done_o), 32'd0);
    chk("sb_datal_untouched", dm_data_l_o, 32'hAABBCCDD);
    req(1'b1, 1'b0, 3'b010, 32'h4, 32'h0);
    step();
    chk("lw_strobe_n4", 32'(dm_load_o), 32'd1);
    chk("lw_addr", dm_addr_o, 32'h4);
    chk("lw_sel", 32'(dm_data_select_o), 32'b1111);
    step();
    chk("lw_done", 32'(dm_load_done_o), 32'd1);
    chk("lw_data", dm_data_l_o, 32'h12345678);
    dm_ready_i = 1'b0; idle_in();
    step();

    // Load and store both high with invalid fun 111: load wins, word access
    req(1'b1, 1'b1, 3'b111, 32'h8, 32'hCAFEF00D);
    step();
    chk("ls_load_wins", 32'({dm_load_o, dm_store_o}), 32'b10);
    chk("ls_sel_word", 32'(dm_data_select_o), 32'b1111);
    chk("ls_data_word", dm_data_s_o, 32'hCAFEF00D);
    idle_in();
    dm_ready_i = 1'b1; dm_data_l_i = 32'h0BADF00D;
    step();
    chk("ls_done", 32'({dm_load_done_o, dm_store_done_o}), 32'b10);
    chk("ls_data", dm_data_l_o, 32'h0BADF00D);
    dm_ready_i = 1'b0;
    step();

    // Reset during WAIT
    req(1'b1, 1'b0, 3'b010, 32'h20, 32'h0);
    step();
    chk("rw_strobe", 32'(dm_load_o), 32'd1);
    idle_in();
    step();
    chk("rw_hold_after_valid_drop", 32'(dm_load_o), 32'd1);
    rst_n_i = 1'b0;
    step();
    chk("rw_strobe_drop", 32'(dm_load_o), 32'd0);
    chk("rw_no_done", 32'(dm_load_done_o), 32'd0);
    chk("rw_datal_clr", dm_data_l_o, 32'h0);
    rst_n_i = 1'b1;
    step();
    chk("rw_idle", 32'({dm_load_o, dm_load_done_o}), 32'd0);
    req(1'b1, 1'b0, 3'b010, 32'h24, 32'h0);
    step();
    chk("rw_new_strobe", 32'(dm_load_o), 32'd1);
    chk("rw_new_addr", dm_addr_o, 32'h24);
    dm_ready_i = 1'b1; dm_data_l_i = 32'h00005A5A;
    step();
    chk("rw_new_done", 32'(dm_load_done_o), 32'd1);
    chk("rw_new_data", dm_data_l_o, 32'h00005A5A);
    dm_ready_i = 1'b0; idle_in();
    step();

    // Bus never ready
    req(1'b1, 1'b0, 3'b010, 32'h40, 32'h0);
    step();
    chk("to_strobe", 32'(dm_load_o), 32'd1);
    idle_in();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("to_strobe_hold", 32'(dm_load_o), 32'd1);
    end
    step();
`ifdef URV_DM_TIMEOUT_EN
    chk("to_done", 32'(dm_load_done_o), 32'd1);
    chk("to_error", 32'(dm_error_o), 32'd1);
    chk("to_strobe_drop", 32'(dm_load_o), 32'd0);
    chk("to_data_zero", dm_data_l_o, 32'h0);
    step();
    chk("to_pulse", 32'({dm_load_done_o, dm_error_o}), 32'd0);
`else
    for (int i = 0; i < 4; i++) begin
      chk("nto_strobe_hold", 32'(dm_load_o), 32'd1);
      chk("nto_no_error", 32'({dm_load_done_o, dm_error_o}), 32'd0);
      step();
    end
    dm_ready_i = 1'b1; dm_data_l_i = 32'h600DD00D;
    step();
    chk("nto_done", 32'(dm_load_done_o), 32'd1);
    chk("nto_data", dm_data_l_o, 32'h600DD00D);
    dm_ready_i = 1'b0;
    step();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
